// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown controller.
// State encoding and BCD constants.
package countdown_pkg;

    localparam int BCD_W     = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/bcd_down_counter.sv
// N-digit BCD register with parallel load and decrement-by-one.
// The decrement ripples a borrow from digit 0 upward.
module bcd_down_counter
    import countdown_pkg::*;
#(
    parameter int N_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [BCD_W*N_DIGITS-1:0] load_val,
    input  logic                      dec,
    output logic [BCD_W*N_DIGITS-1:0] value,
    output logic                      is_one,
    output logic                      is_zero
);

    localparam int W = BCD_W * N_DIGITS;

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W-1:0] dec_val;
    logic         borrow;

    // Borrow chain: a zero digit under borrow wraps to 9 and passes it on.
    always_comb begin
        dec_val = value_q;
        borrow  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (borrow) begin
                if (value_q[i*BCD_W +: BCD_W] == 4'd0) begin
                    dec_val[i*BCD_W +: BCD_W] = 4'(MAX_DIGIT);
                end else begin
                    dec_val[i*BCD_W +: BCD_W] =
                        value_q[i*BCD_W +: BCD_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Load wins over decrement.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec) begin
            value_d = dec_val;
        end
    end

    // Value register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign is_zero = (value_q == '0);
    assign is_one  = (value_q == W'(1));

endmodule

// File: rtl/countdown_ctrl.sv
// Keypad-driven N-digit BCD countdown: entry, start/pause, alarm.
// Optional COUNTDOWN_AUTORELOAD_EN reloads on zero and adds reload_count.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int N_DIGITS     = 2,
    parameter int ALARM_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      keydown_num,
    input  logic [3:0]                num,
    input  logic                      keydown_start,
    input  logic                      keydown_confirm,
    input  logic                      keydown_clear,
    output logic [BCD_W*N_DIGITS-1:0] entry_bcd,
    output logic [BCD_W*N_DIGITS-1:0] remaining_bcd,
    output logic                      display_en,
    output logic                      running,
    output logic                      done,
`ifdef COUNTDOWN_AUTORELOAD_EN
    output logic                      alarm,
    output logic [7:0]                reload_count
`else
    output logic                      alarm
`endif
);

    localparam int W  = BCD_W * N_DIGITS;
    localparam int AW = (ALARM_CYCLES < 2) ? 1 : $clog2(ALARM_CYCLES + 1);
    localparam logic [AW-1:0] ALARM_LAST =
        AW'((ALARM_CYCLES > 0) ? ALARM_CYCLES - 1 : 0);

    state_e        state_q, state_d;
    logic [W-1:0]  entry_q, entry_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          done_q, done_d;
    logic          disp_q, run_q, alarm_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [7:0]    reload_q, reload_d;
`endif

    logic          cnt_load;
    logic [W-1:0]  cnt_load_val;
    logic          cnt_dec;
    logic [W-1:0]  cnt_value;
    logic          cnt_is_one;
    logic          cnt_is_zero;

    bcd_down_counter #(
        .N_DIGITS (N_DIGITS)
    ) u_remain (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .is_one   (cnt_is_one),
        .is_zero  (cnt_is_zero)
    );

    // Next state: one event per cycle, clear > start > confirm > num > tick.
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        alarm_cnt_d  = alarm_cnt_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d     = reload_q;
`endif
        if (keydown_clear) begin
            state_d     = ST_IDLE;
            entry_d     = '0;
            cnt_load    = 1'b1;
            alarm_cnt_d = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_d    = '0;
`endif
        end else if (keydown_start) begin
            case (state_q)
                ST_READY: state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_DONE: begin
                    state_d     = ST_IDLE;
                    entry_d     = '0;
                    cnt_load    = 1'b1;
                    alarm_cnt_d = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    reload_d    = '0;
`endif
                end
                default: ;
            endcase
        end else if (keydown_confirm) begin
            if (state_q == ST_ENTRY && entry_q != '0) begin
                cnt_load     = 1'b1;
                cnt_load_val = entry_q;
                state_d      = ST_READY;
            end
        end else if (keydown_num) begin
            if (num <= 4'(MAX_DIGIT) &&
                (state_q == ST_IDLE || state_q == ST_ENTRY ||
                 state_q == ST_READY)) begin
                entry_d              = entry_q << BCD_W;
                entry_d[BCD_W-1:0]   = num;
                state_d              = ST_ENTRY;
            end
        end else if (tick) begin
            if (state_q == ST_RUN) begin
                if (cnt_is_one) begin
                    done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    cnt_load     = 1'b1;
                    cnt_load_val = entry_q;
                    if (reload_q != 8'hFF) begin
                        reload_d = reload_q + 8'd1;
                    end
`else
                    cnt_dec     = 1'b1;
                    state_d     = ST_DONE;
                    alarm_cnt_d = '0;
`endif
                end else if (!cnt_is_zero) begin
                    cnt_dec = 1'b1;
                end
            end else if (state_q == ST_DONE) begin
                if (ALARM_CYCLES != 0 && alarm_cnt_q == ALARM_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_load    = 1'b1;
                    alarm_cnt_d = '0;
                end else if (alarm_cnt_q != '1) begin
                    alarm_cnt_d = alarm_cnt_q + AW'(1);
                end
            end
        end
    end

    // State, entry, alarm counter and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            alarm_cnt_q <= '0;
            done_q      <= 1'b0;
            disp_q      <= 1'b0;
            run_q       <= 1'b0;
            alarm_q     <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            alarm_cnt_q <= alarm_cnt_d;
            done_q      <= done_d;
            disp_q      <= (state_d != ST_IDLE);
            run_q       <= (state_d == ST_RUN);
            alarm_q     <= (state_d == ST_DONE);
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q    <= reload_d;
`endif
        end
    end

    assign entry_bcd     = entry_q;
    assign remaining_bcd = cnt_value;
    assign display_en    = disp_q;
    assign running       = run_q;
    assign done          = done_q;
    assign alarm         = alarm_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
    assign reload_count  = reload_q;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus
// random single-event traffic against a decimal reference model.
module tb_countdown_ctrl;

    localparam int N   = 2;
    localparam int AC  = 16;
    localparam int W   = 4 * N;
    localparam int MOD = 100;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_READY = 2;
    localparam int M_RUN   = 3;
    localparam int M_PAUSE = 4;
    localparam int M_DONE  = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick;
    logic         keydown_num;
    logic [3:0]   num;
    logic         keydown_start;
    logic         keydown_confirm;
    logic         keydown_clear;
    logic [W-1:0] entry_bcd;
    logic [W-1:0] remaining_bcd;
    logic         display_en;
    logic         running;
    logic         done;
    logic         alarm;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [7:0]   reload_count;
`endif

    always #5 clk = ~clk;

    countdown_ctrl #(
        .N_DIGITS     (N),
        .ALARM_CYCLES (AC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick            (tick),
        .keydown_num     (keydown_num),
        .num             (num),
        .keydown_start   (keydown_start),
        .keydown_confirm (keydown_confirm),
        .keydown_clear   (keydown_clear),
        .entry_bcd       (entry_bcd),
        .remaining_bcd   (remaining_bcd),
        .display_en      (display_en),
        .running         (running),
        .done            (done),
`ifdef COUNTDOWN_AUTORELOAD_EN
        .alarm           (alarm),
        .reload_count    (reload_count)
`else
        .alarm           (alarm)
`endif
    );

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;

    int m_st, m_ent, m_rem, m_acnt, m_rc;
    bit m_done;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_clear();
        m_st   = M_IDLE;
        m_ent  = 0;
        m_rem  = 0;
        m_acnt = 0;
        m_rc   = 0;
    endtask

    task automatic model_step(input bit t, input bit n, input int nv,
                              input bit s, input bit cf, input bit cl);
        m_done = 0;
        if (cl) begin
            model_clear();
        end else if (s) begin
            if (m_st == M_READY || m_st == M_PAUSE) m_st = M_RUN;
            else if (m_st == M_RUN) m_st = M_PAUSE;
            else if (m_st == M_DONE) model_clear();
        end else if (cf) begin
            if (m_st == M_ENTRY && m_ent != 0) begin
                m_rem = m_ent;
                m_st  = M_READY;
            end
        end else if (n) begin
            if (nv <= 9 && m_st <= M_READY) begin
                m_ent = (m_ent * 10 + nv) % MOD;
                m_st  = M_ENTRY;
            end
        end else if (t) begin
            if (m_st == M_RUN) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    m_rem = m_ent;
                    if (m_rc < 255) m_rc++;
`else
                    m_st   = M_DONE;
                    m_acnt = 0;
`endif
                end
            end else if (m_st == M_DONE) begin
                m_acnt++;
                if (AC != 0 && m_acnt == AC) begin
                    m_st  = M_IDLE;
                    m_rem = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit t, input bit n, input int nv,
                         input bit s, input bit cf, input bit cl,
                         input bit r);
        @(negedge clk);
        tick            = t;
        keydown_num     = n;
        num             = 4'(nv);
        keydown_start   = s;
        keydown_confirm = cf;
        keydown_clear   = cl;
        rst_n           = r;
        @(posedge clk);
        #1;
        tick            = 0;
        keydown_num     = 0;
        keydown_start   = 0;
        keydown_confirm = 0;
        keydown_clear   = 0;
        rst_n           = 1;
        if (!r) begin
            model_clear();
            m_done = 0;
        end else begin
            model_step(t, n, nv, s, cf, cl);
        end
        if (done) done_seen++;
        check("entry", 32'(entry_bcd), 32'(to_bcd(m_ent)));
        check("remaining", 32'(remaining_bcd), 32'(to_bcd(m_rem)));
        check("display_en", 32'(display_en), 32'(m_st != M_IDLE));
        check("running", 32'(running), 32'(m_st == M_RUN));
        check("done", 32'(done), 32'(m_done));
        check("alarm", 32'(alarm), 32'(m_st == M_DONE));
`ifdef COUNTDOWN_AUTORELOAD_EN
        check("reload_count", 32'(reload_count), 32'(m_rc));
`endif
    endtask

    task automatic key(input int d);
        cycle(0, 1, d, 0, 0, 0, 1);
    endtask

    task automatic tk();
        cycle(1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic start();
        cycle(0, 0, 0, 1, 0, 0, 1);
    endtask

    task automatic confirm();
        cycle(0, 0, 0, 0, 1, 0, 1);
    endtask

    task automatic clear();
        cycle(0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        int sel;
        tick            = 0;
        keydown_num     = 0;
        num             = 0;
        keydown_start   = 0;
        keydown_confirm = 0;
        keydown_clear   = 0;
        rst_n           = 0;
        model_clear();
        m_done = 0;

        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("rst_entry", 32'(entry_bcd), 32'h0);
        check("rst_disp", 32'(display_en), 32'h0);

        // 42-second countdown to DONE, then alarm timeout
        key(4);
        key(2);
        confirm();
        start();
        tk();
        check("t1_first_tick", 32'(remaining_bcd), 32'h41);
        done_seen = 0;
        repeat (41) tk();
`ifndef COUNTDOWN_AUTORELOAD_EN
        check("t1_done_once", 32'(done_seen), 32'd1);
        check("t1_alarm", 32'(alarm), 32'd1);
        check("t1_rem_zero", 32'(remaining_bcd), 32'h0);
        repeat (15) tk();
        check("t1_alarm_held", 32'(alarm), 32'd1);
        tk();
        check("t1_alarm_off", 32'(alarm), 32'd0);
        check("t1_idle", 32'(display_en), 32'd0);
        check("t1_entry_kept", 32'(entry_bcd), 32'h42);
`endif

        // entry shift, invalid digit, zero confirm
        clear();
        key(1);
        key(2);
        key(3);
        check("t2_shift", 32'(entry_bcd), 32'h23);
        key(11);
        check("t2_bad_digit", 32'(entry_bcd), 32'h23);
        clear();
        key(0);
        confirm();
        check("t2_zero_confirm_rem", 32'(remaining_bcd), 32'h0);
        check("t2_zero_confirm_disp", 32'(display_en), 32'd1);
        key(5);
        confirm();
        check("t2_confirm5", 32'(remaining_bcd), 32'h05);

        // borrow and pause
        clear();
        key(1);
        key(0);
        confirm();
        start();
        tk();
        check("t3_borrow", 32'(remaining_bcd), 32'h09);
        start();
        repeat (3) tk();
        check("t3_paused", 32'(remaining_bcd), 32'h09);
        start();
        tk();
        check("t3_resume", 32'(remaining_bcd), 32'h08);

        // simultaneous events
        cycle(0, 0, 0, 1, 0, 1, 1);
        check("t4_clr_start_rem", 32'(remaining_bcd), 32'h0);
        check("t4_clr_start_run", 32'(running), 32'd0);
        key(2);
        key(5);
        confirm();
        cycle(1, 0, 0, 1, 0, 0, 1);
        check("t4_start_tick_run", 32'(running), 32'd1);
        check("t4_start_tick_rem", 32'(remaining_bcd), 32'h25);

        // reset mid-run
        tk();
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("t5_rst_run", 32'(running), 32'd0);
        check("t5_rst_rem", 32'(remaining_bcd), 32'h0);
        check("t5_rst_done", 32'(done), 32'd0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        clear();
        key(3);
        confirm();
        start();
        done_seen = 0;
        repeat (9) tk();
        check("t6_done_cnt", 32'(done_seen), 32'd3);
        check("t6_reloads", 32'(reload_count), 32'd3);
        check("t6_running", 32'(running), 32'd1);
        check("t6_rem", 32'(remaining_bcd), 32'h03);
`endif

        // random single-event traffic
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 35) tk();
            else if (sel < 65) key($urandom_range(0, 15));
            else if (sel < 75) start();
            else if (sel < 85) confirm();
            else if (sel < 87) clear();
            else cycle(0, 0, 0, 0, 0, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Parametrised successor to the fixed two-digit countdown logic. Provides N-digit BCD keypad entry, a confirm/start/pause/clear state machine, and a per-second BCD decrement. Runs on the single system clock and uses single-cycle enable pulses (key strobes, 1 Hz tick) instead of divided clocks. Sits between the keypad scanner and the 7-segment display driver, feeding BCD digits directly so no decimal splitter is needed.

Parameters:
N_DIGITS, 2, number of BCD digits for both the entry value and the remaining value (range 1..8).
ALARM_CYCLES, 16, number of ticks alarm stays asserted in DONE before auto-return to IDLE (0 = hold until key).

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  synchronous active-low reset
tick  in  1  one-clk pulse per second
keydown_num  in  1  one-clk pulse, digit key pressed
num  in  4  digit value, valid with keydown_num
keydown_start  in  1  one-clk pulse, start/pause key
keydown_confirm  in  1  one-clk pulse, confirm key
keydown_clear  in  1  one-clk pulse, clear key
entry_bcd  out  4*N_DIGITS  entered/confirmed amount, digit 0 = LSB nibble
remaining_bcd  out  4*N_DIGITS  remaining time, BCD
display_en  out  1  display enable
running  out  1  high in RUN
done  out  1  one-clk pulse on reaching zero
alarm  out  1  high in DONE

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; entry_bcd, remaining_bcd = 0; display_en, running, done, alarm = 0; alarm counter = 0.
- States: IDLE, ENTRY, READY, RUN, PAUSE, DONE. All outputs are registered, so an output changes on the edge after the causing pulse.
- Event priority within a cycle: clear > start > confirm > num > tick. The lower-priority event is ignored on that cycle.
- clear: from any state go to IDLE and zero entry_bcd and remaining_bcd.
- keydown_num with num <= 9, in IDLE/ENTRY/READY: entry_bcd shifts left one nibble, the new digit goes into nibble 0, and the top digit is discarded. State becomes ENTRY. num > 9 is ignored. Ignored in RUN/PAUSE/DONE.
- confirm in ENTRY: if entry_bcd != 0, copy it to remaining_bcd and go to READY; if entry_bcd == 0, stay in ENTRY. Confirm is ignored in all other states.
- start: READY -> RUN; RUN -> PAUSE; PAUSE -> RUN. Ignored in IDLE and ENTRY. In DONE, start behaves as clear.
- tick in RUN: BCD decrement remaining_bcd by 1. Each digit 0 borrows and becomes 9.
  - If remaining_bcd == 1 before the tick, it becomes 0, state goes to DONE, and done pulses for exactly one clk.
  - Ticks in other states are ignored.
- DONE: alarm = 1. Each tick increments the alarm counter. When ALARM_CYCLES != 0 and the counter reaches ALARM_CYCLES, go to IDLE, keep entry_bcd, and zero remaining_bcd.
- display_en = 0 in IDLE, 1 otherwise. running = (state == RUN).
- Reset asserted mid-RUN aborts immediately. No done pulse is generated.

Optional Feature:
Macro COUNTDOWN_AUTORELOAD_EN.
- Defined: on reaching zero in RUN, done pulses, remaining_bcd is reloaded from entry_bcd on the same edge, and state stays RUN. DONE and alarm are never entered from RUN. An extra output reload_count (8 bits, saturating at 255) counts reloads and is zeroed by clear or reset.
- Undefined: behaviour as above; no reload_count port.

Decomposition:
- Shared package/include countdown_pkg holds:
  - the state encoding (3-bit localparams ST_IDLE..ST_DONE),
  - BCD_W = 4,
  - MAX_DIGIT = 9.
- One sub-module, bcd_down_counter (parameter N_DIGITS):
  - inputs: load, load_val, dec;
  - outputs: value, is_one, is_zero;
  - implemented as a per-digit borrow chain.
- countdown_ctrl holds the FSM, the entry shift register and the alarm counter.

Test Plan:
- N_DIGITS=2: keys 4,2, confirm, start, then 42 ticks -> remaining 0x41 after the first tick, 0x00 after the 42nd; done pulses once; alarm=1; state DONE.
- Keys 1,2,3 with N_DIGITS=2 -> entry_bcd=0x23; key 11 (num>9) -> unchanged; confirm with entry 0x00 after clear -> stays in ENTRY, remaining 0.
- Amount 0x10, start, 1 tick -> 0x09 (borrow); start -> PAUSE; 3 ticks -> still 0x09; start, 1 tick -> 0x08.
- Simultaneous clear+start in RUN -> IDLE with all values 0; simultaneous start+tick in READY -> RUN with remaining unchanged.
- ALARM_CYCLES=16: reach DONE, 16 ticks -> IDLE, entry kept, remaining 0, alarm 0. rst_n low mid-RUN -> all outputs 0 on the next edge.
- COUNTDOWN_AUTORELOAD_EN, amount 0x03: 9 ticks -> 3 done pulses, reload_count=3, running stays 1, remaining=0x03.
